// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes four BCD digits onto a common-anode display with blanking, zero suppression and frame-aligned updates.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : strobe capturing digits_in / dp_in
//   digits_in, dp_in  : four BCD digits ([3:0] rightmost) and their decimal points
//   lz_en             : leading-zero suppression enable
//   bcd_out           : code of the selected digit for the shared segment decoder
//   an, dp_n          : active-low anode selects and decimal point
//   frame_tick        : one-cycle pulse per completed 4-digit frame
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BL = CW'(BLANK_CYCLES);
    typedef enum logic {BLANK, DRIVE} state_t;
    localparam state_t RST_ST = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0] idx;
    logic [15:0] act_d, sh_d;
    logic [3:0] act_dp, sh_dp;
    logic pending, boundary, sup, inv, lit, dp_nx;
    logic [3:0] dig, an_nx, bcd_nx;
    always_comb begin
        boundary = (cnt == LAST) && (idx == 2'd3);
        cnt_nx = (cnt == LAST) ? '0 : cnt + 1'b1;
        // State tracks the slot position the counter is about to enter.
        state_nx = (cnt_nx < BL) ? BLANK : DRIVE;
        dig = act_d[{idx, 2'b00} +: 4];
        inv = dig > 4'd9;
        // A digit is a leading zero only if it and every digit to its left are zero.
        sup = lz_en && (idx == 2'd3 ? act_d[15:12] == 4'd0 :
                        idx == 2'd2 ? act_d[15:8] == 8'd0 :
                        idx == 2'd1 ? act_d[15:4] == 12'd0 : 1'b0);
        lit = (state == DRIVE) && !sup && !inv;
        an_nx = lit ? ~(4'b0001 << idx) : 4'b1111;
        dp_nx = lit ? ~act_dp[idx] : 1'b1;
        bcd_nx = inv ? 4'd0 : dig;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_ST;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
            act_d <= 16'd0;
            act_dp <= 4'd0;
            sh_d <= 16'd0;
            sh_dp <= 4'd0;
            pending <= 1'b0;
            an <= 4'b1111;
            dp_n <= 1'b1;
            bcd_out <= 4'd0;
            frame_tick <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            if (cnt == LAST) idx <= idx + 2'd1;
            an <= an_nx;
            dp_n <= dp_nx;
            bcd_out <= bcd_nx;
            frame_tick <= boundary;
            if (load) begin
                sh_d <= digits_in;
                sh_dp <= dp_in;
            end
            // Active data only changes on the edge that starts a new frame.
            if (boundary && load) begin
                act_d <= digits_in;
                act_dp <= dp_in;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                act_d <= sh_d;
                act_dp <= sh_dp;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed frame-by-frame check of seven_seg_scanner with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scanner;
    logic clk = 1'b0, rst_n = 1'b1, load = 1'b0, lz_en = 1'b0;
    logic [15:0] digits_in = 16'hDEAD;
    logic [3:0] dp_in = 4'hA;
    logic [3:0] bcd_out, an;
    logic dp_n, frame_tick;
    int errors = 0, checks = 0;

    seven_seg_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .lz_en(lz_en), .bcd_out(bcd_out), .an(an), .dp_n(dp_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Runs np cycles of a frame starting at slot position 0, sampling on the falling edge.
    // Loads (la/lb = position, -1 for none) are captured on the edge leaving that position.
    task automatic frame(input int f, input logic [15:0] ebcd, input logic [15:0] ean, input logic [3:0] edp,
                         input int np, input int la, input logic [15:0] da, input logic [3:0] dpa,
                         input int lb, input logic [15:0] db, input logic [3:0] dpb);
        for (int p = 0; p < np; p++) begin
            int s, c;
            s = p / 8;
            c = p % 8;
            load = (p == la) || (p == lb);
            digits_in = (p == la) ? da : (p == lb) ? db : 16'hDEAD;
            dp_in = (p == la) ? dpa : (p == lb) ? dpb : 4'hA;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("f%0d p%0d an", f, p), {12'd0, an}, {12'd0, (c < 2) ? 4'hF : ean[s*4 +: 4]});
            chk($sformatf("f%0d p%0d bcd", f, p), {12'd0, bcd_out}, {12'd0, ebcd[s*4 +: 4]});
            chk($sformatf("f%0d p%0d dp_n", f, p), {15'd0, dp_n}, {15'd0, (c < 2) ? 1'b1 : edp[s]});
            chk($sformatf("f%0d p%0d tick", f, p), {15'd0, frame_tick}, {15'd0, p == 31});
        end
        load = 1'b0;
        digits_in = 16'hDEAD;
        dp_in = 4'hA;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst an", {12'd0, an}, 16'h000F);
        chk("rst dp_n", {15'd0, dp_n}, 16'h0001);
        chk("rst bcd", {12'd0, bcd_out}, 16'h0000);
        chk("rst tick", {15'd0, frame_tick}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        frame(0, 16'h0000, 16'h7BDE, 4'hF, 32, 0, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
        frame(1, 16'h1234, 16'h7BDE, 4'hF, 32, 8, 16'h5678, 4'h0, -1, 16'h0, 4'h0);
        frame(2, 16'h5678, 16'h7BDE, 4'hF, 32, 3, 16'h1111, 4'h0, 31, 16'h9999, 4'h0);
        frame(3, 16'h9999, 16'h7BDE, 4'hF, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        frame(4, 16'h9999, 16'h7BDE, 4'hF, 32, 4, 16'h2222, 4'hF, 20, 16'h0070, 4'h0);
        lz_en = 1'b1;
        frame(5, 16'h0070, 16'hFFDE, 4'hF, 32, 0, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
        frame(6, 16'h0000, 16'hFFFE, 4'hF, 32, 0, 16'h00A1, 4'b0001, -1, 16'h0, 4'h0);
        lz_en = 1'b0;
        frame(7, 16'h0001, 16'h7BFE, 4'b1110, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        frame(8, 16'h0001, 16'h7BFE, 4'b1110, 19, 17, 16'h4321, 4'h0, -1, 16'h0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst an", {12'd0, an}, 16'h000F);
        chk("mid rst dp_n", {15'd0, dp_n}, 16'h0001);
        chk("mid rst bcd", {12'd0, bcd_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        frame(9, 16'h0000, 16'h7BDE, 4'hF, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        frame(10, 16'h0000, 16'h7BDE, 4'hF, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
